// File: rtl/regfile_scoreboard_if.sv
// Writeback / decode bus between the pipeline and the register file.
// master drives the pipeline side (writeback, issue, read numbers); slave is the register file.
interface regfile_scoreboard_if #(
  parameter int WIDTH = 16,
  parameter int NUM_W = 3
);
  logic             write_in;
  logic [NUM_W-1:0] writenum_in;
  logic [WIDTH-1:0] writeback_data_in;
  logic [NUM_W-1:0] readnum_a_in;
  logic [NUM_W-1:0] readnum_b_in;
  logic [WIDTH-1:0] rdata_a_out;
  logic [WIDTH-1:0] rdata_b_out;
  logic             issue_in;
  logic [NUM_W-1:0] issue_num_in;
  logic             flush_in;
  logic             hazard_out;
  logic             overflow_out;

  modport master (
    output write_in, writenum_in, writeback_data_in,
    output readnum_a_in, readnum_b_in,
    output issue_in, issue_num_in, flush_in,
    input  rdata_a_out, rdata_b_out, hazard_out, overflow_out
  );

  modport slave (
    input  write_in, writenum_in, writeback_data_in,
    input  readnum_a_in, readnum_b_in,
    input  issue_in, issue_num_in, flush_in,
    output rdata_a_out, rdata_b_out, hazard_out, overflow_out
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// 8 x 16-bit register file with write-first registered read ports and a
// per-register pending-write counter used by decode for RAW hazard stalls.
module regfile_scoreboard #(
  parameter int WIDTH     = 16,
  parameter int NREGS     = 8,
  parameter int PEND_BITS = 2
) (
  input  logic clk,
  input  logic rst,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;

  logic [WIDTH-1:0]     regs_q [NREGS];
  logic [WIDTH-1:0]     regs_d [NREGS];
  logic [PEND_BITS-1:0] pend_q [NREGS];
  logic [PEND_BITS-1:0] pend_d [NREGS];
  logic [WIDTH-1:0]     rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0]     rdata_b_q, rdata_b_d;
  logic                 overflow_q, overflow_d;

  // Reads come from the post-write array so a same-cycle writeback is bypassed.
  always_comb begin
    regs_d = regs_q;
    if (bus.write_in) regs_d[bus.writenum_in] = bus.writeback_data_in;
    rdata_a_d = regs_d[bus.readnum_a_in];
    rdata_b_d = regs_d[bus.readnum_b_in];
  end

  always_comb begin
    logic inc, dec;
    pend_d     = pend_q;
    overflow_d = overflow_q;
    for (int r = 0; r < NREGS; r++) begin
      inc = bus.issue_in && (bus.issue_num_in == AW'(r));
      dec = bus.write_in && (bus.writenum_in == AW'(r)) && (pend_q[r] != '0);
      if (inc && (pend_q[r] == PEND_MAX)) overflow_d = 1'b1;
      if (inc && !dec && (pend_q[r] != PEND_MAX)) pend_d[r] = pend_q[r] + 1'b1;
      else if (dec && !inc) pend_d[r] = pend_q[r] - 1'b1;
      if (bus.flush_in) pend_d[r] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      overflow_q <= overflow_d;
    end
  end

  // Hazard looks only at committed counter state; same-cycle issue/writeback is not forwarded.
  assign bus.hazard_out   = (pend_q[bus.readnum_a_in] != '0) || (pend_q[bus.readnum_b_in] != '0);
  assign bus.rdata_a_out  = rdata_a_q;
  assign bus.rdata_b_out  = rdata_b_q;
  assign bus.overflow_out = overflow_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: the driver updates a behavioural model and queues the expected
// post-edge outputs; an independent monitor pops and compares after every edge.
module tb_regfile_scoreboard;
  logic clk;
  logic rst;

  regfile_scoreboard_if #(.WIDTH(16), .NUM_W(3)) bus ();

  regfile_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ra;
    logic [15:0] rb;
    logic        haz;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  int          tests = 0;
  int          fails = 0;
  logic [15:0] m_regs [8];
  int          m_pend [8];
  logic        m_ovf;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model across the coming edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [2:0] wn,
                               input logic [15:0] wd, input logic [2:0] ra,
                               input logic [2:0] rb, input logic iss,
                               input logic [2:0] inum, input logic fl);
    exp_t e;
    @(negedge clk);
    rst                   = r;
    bus.write_in          = w;
    bus.writenum_in       = wn;
    bus.writeback_data_in = wd;
    bus.readnum_a_in      = ra;
    bus.readnum_b_in      = rb;
    bus.issue_in          = iss;
    bus.issue_num_in      = inum;
    bus.flush_in          = fl;
    if (!r) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 0;
      end
      m_ovf = 1'b0;
      e.ra  = '0;
      e.rb  = '0;
    end else begin
      if (w) m_regs[wn] = wd;
      e.ra = m_regs[ra];
      e.rb = m_regs[rb];
      if (fl) begin
        if (iss && m_pend[inum] == 3) m_ovf = 1'b1;
        for (int i = 0; i < 8; i++) m_pend[i] = 0;
      end else begin
        int delta [8];
        for (int i = 0; i < 8; i++) delta[i] = 0;
        if (iss) begin
          if (m_pend[inum] == 3) m_ovf = 1'b1;
          else delta[inum] += 1;
        end
        if (w && m_pend[wn] > 0) delta[wn] -= 1;
        if (iss && w && inum == wn && m_pend[wn] == 3) delta[wn] = 0;
        for (int i = 0; i < 8; i++) m_pend[i] += delta[i];
      end
    end
    e.haz = (m_pend[ra] != 0) || (m_pend[rb] != 0);
    e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("rdata_a", bus.rdata_a_out, e.ra);
        checkOutput("rdata_b", bus.rdata_b_out, e.rb);
        checkOutput("hazard", {15'b0, bus.hazard_out}, {15'b0, e.haz});
        checkOutput("overflow", {15'b0, bus.overflow_out}, {15'b0, e.ovf});
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    rst = 1'b0;
    bus.write_in = 1'b0; bus.writenum_in = '0; bus.writeback_data_in = '0;
    bus.readnum_a_in = '0; bus.readnum_b_in = '0;
    bus.issue_in = 1'b0; bus.issue_num_in = '0; bus.flush_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end
    m_ovf = 1'b0;

    // Reset then read
    applyStimulus(0, 1, 3'd3, 16'hAAAA, 3'd3, 3'd5, 1, 3'd3, 0);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd3, 3'd5, 0, 3'd0, 0);
    applyStimulus(1, 0, 3'd0, 16'h0, 3'd3, 3'd5, 0, 3'd0, 0);
    // Write/read and bypass
    applyStimulus(1, 1, 3'd2, 16'h1234, 3'd0, 3'd0, 0, 3'd0, 0);
    applyStimulus(1, 0, 3'd0, 16'h0, 3'd2, 3'd2, 0, 3'd0, 0);
    applyStimulus(1, 1, 3'd4, 16'hBEEF, 3'd2, 3'd4, 0, 3'd0, 0);
    // RAW hazard
    applyStimulus(1, 0, 3'd0, 16'h0, 3'd1, 3'd0, 1, 3'd1, 0);
    applyStimulus(1, 1, 3'd1, 16'h0042, 3'd1, 3'd0, 0, 3'd0, 0);
    // Simultaneous inc/dec
    applyStimulus(1, 0, 3'd0, 16'h0, 3'd6, 3'd0, 1, 3'd6, 0);
    applyStimulus(1, 1, 3'd6, 16'h0606, 3'd6, 3'd0, 1, 3'd6, 0);
    applyStimulus(1, 1, 3'd6, 16'h0607, 3'd6, 3'd6, 0, 3'd0, 0);
    // Saturation and underflow
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 3'd0, 16'h0, 3'd7, 3'd0, 1, 3'd7, 0);
    applyStimulus(1, 1, 3'd0, 16'hC0DE, 3'd0, 3'd0, 0, 3'd0, 0);
    applyStimulus(1, 0, 3'd0, 16'h0, 3'd0, 3'd7, 0, 3'd0, 0);
    // Flush priority
    applyStimulus(1, 0, 3'd0, 16'h0, 3'd3, 3'd5, 1, 3'd3, 0);
    applyStimulus(1, 0, 3'd0, 16'h0, 3'd3, 3'd5, 1, 3'd3, 0);
    applyStimulus(1, 0, 3'd0, 16'h0, 3'd3, 3'd5, 1, 3'd5, 0);
    applyStimulus(1, 1, 3'd3, 16'h00FF, 3'd3, 3'd5, 1, 3'd5, 1);
    applyStimulus(1, 0, 3'd0, 16'h0, 3'd3, 3'd7, 0, 3'd0, 0);

    // Randomized traffic with occasional flush and reset
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 2) == 0),
                    3'($urandom_range(0, 7)),
                    16'($urandom),
                    3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0),
                    3'($urandom_range(0, 7)),
                    ($urandom_range(0, 39) == 0));
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      #2;
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Register-file end of the writeback interface: accepts the writeback stage's data, register number and write strobe, and commits them into an 8-entry x 16-bit register file.
- Provides two synchronous read ports for the decode stage, with write-first bypass.
- Keeps a per-register pending-write scoreboard, set at issue and cleared at writeback. Decode uses it to stall on read-after-write hazards.

Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 8, number of registers; register numbers are 3 bits.
- PEND_BITS, 2, width of each per-register pending-write counter (max outstanding writes = 2^PEND_BITS-1 = 3).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- write_in  input  1  writeback strobe from the writeback stage.
- writenum_in  input  3  destination register of the writeback.
- writeback_data_in  input  WIDTH  data to commit.
- readnum_a_in  input  3  read port A register number.
- readnum_b_in  input  3  read port B register number.
- rdata_a_out  output  WIDTH  registered read data, port A.
- rdata_b_out  output  WIDTH  registered read data, port B.
- issue_in  input  1  an instruction that will write a register is leaving decode this cycle.
- issue_num_in  input  3  destination register of the issued instruction.
- flush_in  input  1  pipeline flush: discard all in-flight pending writes.
- hazard_out  output  1  combinational; high when readnum_a_in or readnum_b_in has a nonzero pending count.
- overflow_out  output  1  sticky; high once an issue is attempted on a saturated counter.

Behaviour:
- Reset (rst==0 at a clock edge):
  - all registers, rdata_a_out, rdata_b_out, all pending counters and overflow_out go to 0;
  - hazard_out is therefore 0;
  - write_in, issue_in and flush_in are ignored in that cycle.
- Write:
  - if write_in==1, reg[writenum_in] <= writeback_data_in at the edge.
  - All 8 registers are writable; there is no hardwired zero register.
- Read:
  - 1-cycle latency: rdata_x_out <= reg[readnum_x_in] at each edge.
  - Write-first bypass: if write_in==1 and writenum_in==readnum_x_in in the same cycle, rdata_x_out <= writeback_data_in, never the stale value.
  - Both ports may address the same register; both then receive identical data.
- Scoreboard (per register r, counter pend[r]):
  - inc = issue_in && issue_num_in==r.
  - dec = write_in && writenum_in==r && pend[r]!=0.
  - inc only: pend[r]+1. dec only: pend[r]-1. Both: unchanged. Neither: unchanged.
  - Saturation: inc at pend[r]==3 leaves the counter at 3 and sets overflow_out=1. overflow_out stays high until reset.
  - Writeback to a register with pend[r]==0 commits the data; the counter stays 0 (no underflow).
  - flush_in==1 clears every pend[r] to 0 at the edge. It has priority over inc and dec in the same cycle, but does not block a simultaneous write_in data commit.
  - Upstream must not assert write_in for flushed instructions.
- hazard_out = (pend[readnum_a_in]!=0) || (pend[readnum_b_in]!=0).
  - Evaluated on current counter state only; same-cycle issue or writeback is not forwarded into hazard_out.
  - A register whose final writeback lands this cycle still reads hazard=1 this cycle, but the read data is bypassed correctly. Decode stalls one extra cycle at most; this is accepted.
- Reset mid-operation: counters, registers and overflow_out clear regardless of outstanding writes. A writeback arriving after reset on a zero counter follows the no-underflow rule.

Test Plan:
- Reset then read: hold rst=0 two cycles, release; read A=3, B=5 -> next cycle rdata_a_out=0, rdata_b_out=0, hazard_out=0, overflow_out=0.
- Write/read: write reg2=0x1234, next cycle read A=2 -> rdata_a_out=0x1234 one cycle later. Same-cycle write reg4=0xBEEF with read B=4 -> rdata_b_out=0xBEEF after the edge (bypass).
- Scoreboard RAW: issue reg1 -> next cycle read A=1 gives hazard_out=1. Writeback reg1=0x0042 -> next cycle hazard_out=0 and rdata_a_out=0x0042.
- Simultaneous inc/dec: pend[6]=1; same cycle issue 6 and writeback 6 -> pend[6] stays 1, hazard on reg6 stays 1. Second writeback -> 0.
- Saturation/underflow: issue reg7 four times -> pend[7]=3, overflow_out=1 from the fourth edge on. Writeback reg0 with pend[0]=0 -> data committed, hazard on reg0 stays 0.
- Flush priority: pend[3]=2, pend[5]=1; flush_in=1 with write_in reg3=0x00FF and issue reg5 in the same cycle -> all counters 0, hazard_out=0 for any read, reg3 reads 0x00FF.
